// File: rtl/aes_pkg.sv
// Shared types and constants for the AES ingress loader.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/aes_block_loader_packer.sv
// Beat counter and assembly buffer; packs WORD_W words MSB-slot first into a block.
// Optional byte swap per word under AES_LOADER_BSWAP_EN.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               accept,
    input  logic [WORD_W-1:0]  word,
    input  logic               last,
    output logic               complete,
    output logic               error,
    output logic [BLOCK_W-1:0] next_block,
    output logic [BLOCK_W-1:0] block
);

    localparam int unsigned BEATS = BLOCK_W / WORD_W;
    localparam int unsigned CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic [WORD_W-1:0]  word_pk;
    logic               final_beat;

    always_comb begin
        word_pk = '0;
`ifdef AES_LOADER_BSWAP_EN
        for (int k = 0; k < int'(WORD_W / 8); k++) begin
            word_pk[8*k +: 8] = word[WORD_W-8-8*k +: 8];
        end
`else
        word_pk = word;
`endif
    end

    assign final_beat = (beat_q == CNT_W'(BEATS - 1));

    always_comb begin
        next_block = block_q;
        for (int i = 0; i < int'(BEATS); i++) begin
            if (beat_q == i[CNT_W-1:0]) begin
                next_block[BLOCK_W-1-i*WORD_W -: WORD_W] = word_pk;
            end
        end
    end

    // Any in_last or final beat returns the counter to slot 0, good or bad.
    always_comb begin
        complete = accept && final_beat && last;
        error    = accept && (final_beat != last);
        beat_d   = beat_q;
        block_d  = block_q;
        if (accept) begin
            block_d = next_block;
            beat_d  = (final_beat || last) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q  <= '0;
            block_q <= '0;
        end else begin
            beat_q  <= beat_d;
            block_q <= block_d;
        end
    end

    assign block = block_q;

endmodule

// File: rtl/aes_block_loader.sv
// Double-buffered word-to-block loader feeding the AES pipeline; FILL/FULL FSM and output reg.
// Define AES_LOADER_BSWAP_EN to byte-reverse each input word before packing.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               frame_err
);

    if (BLOCK_W != AES_BLOCK_W) begin : g_bad_block_w
        $error("aes_block_loader: BLOCK_W must be 128");
    end
    if (WORD_W != 8 && WORD_W != 16 && WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("aes_block_loader: WORD_W must be 8, 16, 32 or 64");
    end

    loader_state_e      state_q, state_d;
    aes_block_t         out_block_q, out_block_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q;
    logic               accept, drain, complete, error;
    logic [BLOCK_W-1:0] next_block, asm_block;

    assign in_ready = (state_q == FILL);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    aes_word_packer #(
        .WORD_W  (WORD_W),
        .BLOCK_W (BLOCK_W)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .accept     (accept),
        .word       (in_word),
        .last       (in_last),
        .complete   (complete),
        .error      (error),
        .next_block (next_block),
        .block      (asm_block)
    );

    always_comb begin
        state_d     = state_q;
        out_block_d = out_block_q;
        out_valid_d = drain ? 1'b0 : out_valid_q;
        unique case (state_q)
            FILL: begin
                if (complete) begin
                    // A draining output slot counts as free: no bubble between blocks.
                    if (!out_valid_q || out_ready) begin
                        out_block_d = next_block;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (drain) begin
                    out_block_d = asm_block;
                    out_valid_d = 1'b1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= error;
        end
    end

    assign out_valid = out_valid_q;
    assign out_block = out_block_q;
    assign frame_err = frame_err_q;

endmodule
